// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD countdown counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } state_t;

  // Clamp a raw nibble to a legal BCD digit; anything above 9 becomes 9.
  function automatic logic [3:0] bcd_sanitise(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain. It decrements when the global
// decrement enable and its incoming borrow are both set, wrapping 0 -> 9,
// and passes a borrow on when it is sitting at 0.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       dec,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       borrow_out
);

  // Digit register: load has priority over a borrowed decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (dec && borrow_in) begin
      q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
    end
  end

  assign borrow_out = borrow_in & (q == 4'd0);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown counter with load sanitising, start/stop control,
// a completion pulse and optional automatic reload of the last loaded value.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                stop,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                zero,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] COUNT_ONE = W'(1);

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   reload;
  logic [W-1:0]   sanitised;
  logic           bad_digit;
  logic           digit_ld;
  logic [W-1:0]   digit_ld_val;
  logic           dec;
  logic           done_next;
  logic           count_zero;
  logic [DIGITS:0] borrow;

  // Clamp every incoming digit to 9 and note whether any needed clamping.
  always_comb begin
    sanitised = '0;
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      sanitised[4*d +: 4] = bcd_sanitise(load_val[4*d +: 4]);
      if (load_val[4*d +: 4] > BCD_MAX) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Digit chain: digit 0 always sees a borrow, so a decrement always lands on it.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .ld         (digit_ld),
      .ld_val     (digit_ld_val[4*g +: 4]),
      .dec        (dec),
      .borrow_in  (borrow[g]),
      .q          (count[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  // The borrow ripples all the way out only when every digit reads 0.
  assign count_zero = borrow[DIGITS];
  assign zero       = count_zero;
  assign busy       = (state == RUN);

  // Next-state and datapath control, priority load > stop > start > tick.
  always_comb begin
    state_next   = state;
    digit_ld     = 1'b0;
    digit_ld_val = sanitised;
    dec          = 1'b0;
    done_next    = 1'b0;
    if (load) begin
      digit_ld   = 1'b1;
      state_next = (sanitised != '0) ? ARMED : IDLE;
    end else if (stop) begin
      if (state == RUN) begin
        state_next = ARMED;
      end
    end else if (start && (state == ARMED)) begin
      state_next = RUN;
    end else if (tick && (state == RUN)) begin
      if (count_zero) begin
        if (AUTO_RELOAD != 0) begin
          digit_ld     = 1'b1;
          digit_ld_val = reload;
        end
      end else begin
        dec = 1'b1;
        if (count == COUNT_ONE) begin
          done_next = 1'b1;
          if (AUTO_RELOAD == 0) begin
            state_next = DONE;
          end
        end
      end
    end
  end

  // State, reload value and the single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      reload   <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_next;
      done     <= done_next;
      load_err <= load & bad_digit;
      if (load) begin
        reload <= sanitised;
      end
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for the BCD countdown counter. Two instances share stimulus:
// one plain, one with automatic reload.
module tb_bcd_down_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick = 1'b0;

  logic [15:0] count_a, count_b;
  logic        busy_a, zero_a, done_a, load_err_a;
  logic        busy_b, zero_b, done_b, load_err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(4), .AUTO_RELOAD(0)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .tick(tick),
    .count(count_a), .busy(busy_a), .zero(zero_a),
    .done(done_a), .load_err(load_err_a)
  );

  bcd_down_counter #(.DIGITS(4), .AUTO_RELOAD(1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .tick(tick),
    .count(count_b), .busy(busy_b), .zero(zero_b),
    .done(done_b), .load_err(load_err_b)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] toBcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doLoad(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic doStop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic doTick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    doReset();
    checkOutput("reset count", count_a, 16'h0000);
    checkOutput("reset zero", 16'(zero_a), 16'd1);
    checkOutput("reset busy", 16'(busy_a), 16'd0);
    checkOutput("reset done", 16'(done_a), 16'd0);
    checkOutput("reset load_err", 16'(load_err_a), 16'd0);

    doLoad(16'h0012);
    checkOutput("load 0012 count", count_a, 16'h0012);
    checkOutput("load 0012 busy", 16'(busy_a), 16'd0);
    checkOutput("load 0012 done", 16'(done_a), 16'd0);
    doStart();
    checkOutput("start busy", 16'(busy_a), 16'd1);
    for (int i = 1; i <= 12; i++) begin
      doTick();
      checkOutput($sformatf("down tick %0d count", i), count_a, toBcd(12 - i));
      checkOutput($sformatf("down tick %0d done", i), 16'(done_a), (i == 12) ? 16'd1 : 16'd0);
      checkOutput($sformatf("down tick %0d busy", i), 16'(busy_a), (i == 12) ? 16'd0 : 16'd1);
    end
    checkOutput("at zero flag", 16'(zero_a), 16'd1);
    for (int i = 0; i < 3; i++) begin
      doTick();
      checkOutput("held zero count", count_a, 16'h0000);
      checkOutput("held zero done", 16'(done_a), 16'd0);
    end

    doLoad(16'h1000);
    doStart();
    doTick();
    checkOutput("ripple 1000 count", count_a, 16'h0999);
    checkOutput("ripple 1000 done", 16'(done_a), 16'd0);

    doLoad(16'h0001);
    doStart();
    doTick();
    checkOutput("0001 tick count", count_a, 16'h0000);
    checkOutput("0001 tick done", 16'(done_a), 16'd1);
    doTick();
    checkOutput("0001 extra tick count", count_a, 16'h0000);
    checkOutput("0001 extra tick busy", 16'(busy_a), 16'd0);
    checkOutput("0001 extra tick done", 16'(done_a), 16'd0);

    doLoad(16'h00A5);
    checkOutput("sanitise count", count_a, 16'h0095);
    checkOutput("sanitise load_err", 16'(load_err_a), 16'd1);
    checkOutput("sanitise load done", 16'(done_a), 16'd0);
    step();
    checkOutput("load_err one cycle", 16'(load_err_a), 16'd0);

    doLoad(16'h0000);
    checkOutput("load zero flag", 16'(zero_a), 16'd1);
    checkOutput("load zero load_err", 16'(load_err_a), 16'd0);
    doStart();
    checkOutput("idle start busy", 16'(busy_a), 16'd0);

    doLoad(16'h0050);
    doStart();
    checkOutput("0050 run busy", 16'(busy_a), 16'd1);
    doStop();
    checkOutput("stop busy", 16'(busy_a), 16'd0);
    for (int i = 0; i < 3; i++) begin
      doTick();
    end
    checkOutput("stopped count", count_a, 16'h0050);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    checkOutput("start+stop busy", 16'(busy_a), 16'd0);
    doStart();
    checkOutput("restart busy", 16'(busy_a), 16'd1);
    load = 1'b1;
    load_val = 16'h0123;
    tick = 1'b1;
    step();
    load = 1'b0;
    tick = 1'b0;
    checkOutput("load+tick count", count_a, 16'h0123);
    checkOutput("load+tick busy", 16'(busy_a), 16'd0);
    doStart();
    doTick();
    checkOutput("0123 tick count", count_a, 16'h0122);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid-run rst count", count_a, 16'h0000);
    checkOutput("mid-run rst busy", 16'(busy_a), 16'd0);
    checkOutput("mid-run rst zero", 16'(zero_a), 16'd1);

    doReset();
    doLoad(16'h0002);
    doStart();
    begin
      logic [15:0] exp_cnt [4];
      logic        exp_done [4];
      exp_cnt[0] = 16'h0001; exp_done[0] = 1'b0;
      exp_cnt[1] = 16'h0000; exp_done[1] = 1'b1;
      exp_cnt[2] = 16'h0002; exp_done[2] = 1'b0;
      exp_cnt[3] = 16'h0001; exp_done[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        doTick();
        checkOutput($sformatf("reload tick %0d count", i), count_b, exp_cnt[i]);
        checkOutput($sformatf("reload tick %0d done", i), 16'(done_b), 16'(exp_done[i]));
        checkOutput($sformatf("reload tick %0d busy", i), 16'(busy_b), 16'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
